// File: rtl/counter_sweep_ctrl_if.sv
// Control/counter bundle for counter_sweep_ctrl: request and configuration in,
// counter drive and status out.
interface counter_sweep_ctrl_if #(
  parameter int WIDTH  = 5,
  parameter int LAPS_W = 4
);
  logic              start;
  logic              abort;
  logic              cfg_clear;
  logic [WIDTH-1:0]  cfg_target;
  logic [LAPS_W-1:0] cfg_laps;
  logic [WIDTH-1:0]  cnt_val;
  logic              cnt_en;
  logic              cnt_mode;
  logic              cnt_clr;
  logic              busy;
  logic              done;
  logic [LAPS_W-1:0] lap_cnt;

  modport slave (
    input  start, abort, cfg_clear, cfg_target, cfg_laps, cnt_val,
    output cnt_en, cnt_mode, cnt_clr, busy, done, lap_cnt
  );

  modport master (
    output start, abort, cfg_clear, cfg_target, cfg_laps, cnt_val,
    input  cnt_en, cnt_mode, cnt_clr, busy, done, lap_cnt
  );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Bounce-sweep sequencer for an up/down counter: optional clear, then a
// programmed number of 0 -> target -> 0 laps, ending with a one-cycle done pulse.
module counter_sweep_ctrl #(
  parameter int WIDTH  = 5,
  parameter int LAPS_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  counter_sweep_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, UP, DOWN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  target, target_nxt;
  logic [LAPS_W-1:0] laps, laps_nxt;
  logic [LAPS_W-1:0] lap_cnt, lap_cnt_nxt;
  logic              cnt_en, cnt_mode, cnt_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      target  <= '0;
      laps    <= '0;
      lap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      target  <= target_nxt;
      laps    <= laps_nxt;
      lap_cnt <= lap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    target_nxt  = target;
    laps_nxt    = laps;
    lap_cnt_nxt = lap_cnt;
    cnt_en      = 1'b0;
    cnt_mode    = 1'b0;
    cnt_clr     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          target_nxt  = bus.cfg_target;
          laps_nxt    = (bus.cfg_laps == '0) ? LAPS_W'(1) : bus.cfg_laps;
          lap_cnt_nxt = '0;
          state_nxt   = bus.cfg_clear ? CLEAR : UP;
        end
      end
      // Counter drive is gated by abort so the counter holds its value on the
      // aborting edge.
      CLEAR: begin
        cnt_clr   = !bus.abort;
        state_nxt = UP;
      end
      UP: begin
        cnt_en = (bus.cnt_val != target) && !bus.abort;
        if (bus.cnt_val == target)
          state_nxt = DOWN;
      end
      DOWN: begin
        cnt_mode = 1'b1;
        cnt_en   = (bus.cnt_val != '0) && !bus.abort;
        if (bus.cnt_val == '0) begin
          lap_cnt_nxt = lap_cnt + 1'b1;
          state_nxt   = (lap_cnt_nxt == laps) ? DONE : UP;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort && state != IDLE) begin
      state_nxt   = IDLE;
      lap_cnt_nxt = lap_cnt;
    end
  end

  assign bus.cnt_en   = cnt_en;
  assign bus.cnt_mode = cnt_mode;
  assign bus.cnt_clr  = cnt_clr;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.lap_cnt  = lap_cnt;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl, with a registered 5-bit up/down
// counter model closing the loop on cnt_val.
module tb_counter_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  counter_sweep_ctrl_if #(.WIDTH(5), .LAPS_W(4)) bus ();

  counter_sweep_ctrl #(.WIDTH(5), .LAPS_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Counter under control; ld lets the bench preset a starting value.
  logic       ld;
  logic [4:0] ld_val;
  always_ff @(posedge clk) begin
    if (ld)               bus.cnt_val <= ld_val;
    else if (bus.cnt_clr) bus.cnt_val <= '0;
    else if (bus.cnt_en)  bus.cnt_val <= bus.cnt_mode ? bus.cnt_val - 5'd1 : bus.cnt_val + 5'd1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sweep observation record, sample k is taken after edge E0+k.
  logic [4:0]  vals[$];
  int          done_at, n_done, busy_fall, toggles;
  bit          en_seen, clr_seen, toggle_ok;
  logic [11:0] lap_hist;

  task automatic preload(input logic [4:0] v);
    @(negedge clk); ld = 1'b1; ld_val = v;
    @(negedge clk); ld = 1'b0;
  endtask

  task automatic start_sweep(input logic clr, input logic [4:0] tgt, input logic [3:0] laps);
    @(negedge clk);
    bus.start = 1'b1; bus.cfg_clear = clr; bus.cfg_target = tgt; bus.cfg_laps = laps;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic observe(input int budget, input logic [4:0] tgt);
    logic       prev_mode;
    logic [4:0] prev_val;
    logic [3:0] prev_lap;
    vals.delete();
    done_at = -1; n_done = 0; busy_fall = -1; toggles = 0;
    en_seen = 0; clr_seen = 0; toggle_ok = 1; lap_hist = '0;
    prev_mode = bus.cnt_mode; prev_val = bus.cnt_val; prev_lap = bus.lap_cnt;
    for (int k = 0; k <= budget; k++) begin
      if (k > 0) @(negedge clk);
      vals.push_back(bus.cnt_val);
      if (bus.cnt_en)  en_seen  = 1;
      if (bus.cnt_clr) clr_seen = 1;
      if (k > 0 && bus.cnt_mode != prev_mode) begin
        toggles++;
        if (bus.cnt_val != prev_val || !(bus.cnt_val == 5'd0 || bus.cnt_val == tgt))
          toggle_ok = 0;
      end
      if (bus.lap_cnt != prev_lap) lap_hist = {lap_hist[7:0], bus.lap_cnt};
      if (bus.done) begin n_done++; done_at = k; end
      prev_mode = bus.cnt_mode; prev_val = bus.cnt_val; prev_lap = bus.lap_cnt;
      if (!bus.busy) begin busy_fall = k; break; end
    end
  endtask

  initial begin
    logic [4:0] exp1 [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd3, 5'd2, 5'd1, 5'd0, 5'd0};
    logic [4:0] exp4 [7] = '{5'd30, 5'd31, 5'd0, 5'd1, 5'd1, 5'd0, 5'd0};

    rst = 1'b1; ld = 1'b1; ld_val = 5'd0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_clear = 1'b0;
    bus.cfg_target = '0; bus.cfg_laps = '0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_en",   bus.cnt_en, 0);
    check("rst_mode", bus.cnt_mode, 0);
    check("rst_clr",  bus.cnt_clr, 0);
    check("rst_lap",  bus.lap_cnt, 0);
    @(negedge clk); rst = 1'b0; ld = 1'b0;

    // Clear, target 3, one lap.
    preload(5'd7);
    start_sweep(1'b1, 5'd3, 4'd1);
    check("t1_busy_rise", bus.busy, 1);
    observe(40, 5'd3);
    for (int i = 0; i < 9; i++) check($sformatf("t1_val%0d", i), vals[i+1], exp1[i]);
    check("t1_done_at", done_at, 9);
    check("t1_n_done",  n_done, 1);
    check("t1_busy_fall", busy_fall, 10);
    check("t1_lap", bus.lap_cnt, 1);

    // Clear, target 2, three laps.
    start_sweep(1'b1, 5'd2, 4'd3);
    observe(60, 5'd2);
    check("t2_done_at", done_at, 19);
    check("t2_n_done",  n_done, 1);
    check("t2_laps",    lap_hist, 12'h123);
    check("t2_toggles", toggles, 6);
    check("t2_tog_ok",  toggle_ok, 1);

    // laps=0 behaves as one lap, target 0 never steps.
    start_sweep(1'b1, 5'd0, 4'd0);
    observe(20, 5'd0);
    check("t3_done_at", done_at, 3);
    check("t3_en_seen", en_seen, 0);
    check("t3_lap", bus.lap_cnt, 1);

    // No clear from 30, wraps up through 31 -> 0 -> 1.
    preload(5'd30);
    start_sweep(1'b0, 5'd1, 4'd1);
    observe(20, 5'd1);
    for (int i = 0; i < 7; i++) check($sformatf("t4_val%0d", i), vals[i], exp4[i]);
    check("t4_done_at", done_at, 6);
    check("t4_n_done",  n_done, 1);
    check("t4_clr_seen", clr_seen, 0);

    // Abort in UP at 5 with a stray start mid-run.
    start_sweep(1'b1, 5'd10, 4'd1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) begin
        bus.start = 1'b1; bus.cfg_clear = 1'b0; bus.cfg_target = 5'd3; bus.cfg_laps = 4'd5;
      end else begin
        bus.start = 1'b0;
      end
    end
    check("t5_val_pre", bus.cnt_val, 5);
    check("t5_mode_pre", bus.cnt_mode, 0);
    check("t5_busy_pre", bus.busy, 1);
    bus.abort = 1'b1;
    #1 check("t5_en_abort", bus.cnt_en, 0);
    @(negedge clk); bus.abort = 1'b0;
    check("t5_busy", bus.busy, 0);
    check("t5_en",   bus.cnt_en, 0);
    check("t5_done", bus.done, 0);
    check("t5_lap",  bus.lap_cnt, 0);
    @(negedge clk); @(negedge clk);
    check("t5_hold", bus.cnt_val, 5);
    check("t5_done2", bus.done, 0);

    // Abort wins over start in IDLE.
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.cfg_clear = 1'b1; bus.cfg_target = 5'd2; bus.cfg_laps = 4'd1;
    @(negedge clk); bus.start = 1'b0; bus.abort = 1'b0;
    check("t5_idle_abort_busy", bus.busy, 0);
    check("t5_idle_abort_clr",  bus.cnt_clr, 0);

    // Asynchronous reset mid-DOWN, then a normal sweep.
    start_sweep(1'b1, 5'd3, 4'd1);
    for (int k = 1; k <= 6; k++) @(negedge clk);
    check("t6_mode_pre", bus.cnt_mode, 1);
    check("t6_val_pre",  bus.cnt_val, 2);
    #2 rst = 1'b1;
    #1;
    check("t6_busy", bus.busy, 0);
    check("t6_en",   bus.cnt_en, 0);
    check("t6_mode", bus.cnt_mode, 0);
    check("t6_clr",  bus.cnt_clr, 0);
    check("t6_done", bus.done, 0);
    check("t6_lap",  bus.lap_cnt, 0);
    @(negedge clk); rst = 1'b0;
    start_sweep(1'b1, 5'd1, 4'd1);
    observe(20, 5'd1);
    check("t6_done_at", done_at, 5);
    check("t6_n_done",  n_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Sequencer for the team's 5-bit synchronous up/down counter (mode 0 = up, 1 = down). On a start pulse it optionally clears the counter, then drives it through a programmed number of "bounce" laps (up to a target value, back down to 0). It raises a one-cycle done pulse at the end. It sits between the control/register logic and the counter instance, owning the counter's enable, mode and clear inputs.

## Interface
- WIDTH, 5, counter width; also width of cfg_target and cnt_val
- LAPS_W, 4, width of cfg_laps and lap_cnt
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a sweep
- abort  in  1  terminate the current sweep
- cfg_clear  in  1  clear the counter before the first lap
- cfg_target  in  WIDTH  turnaround value of each lap
- cfg_laps  in  LAPS_W  number of laps; 0 treated as 1
- cnt_val  in  WIDTH  current counter value
- cnt_en  out  1  counter step enable
- cnt_mode  out  1  0 = count up, 1 = count down
- cnt_clr  out  1  counter synchronous clear
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- lap_cnt  out  LAPS_W  laps completed in the current or last sweep

## Operation
- Counter contract at each edge: if cnt_clr, val <= 0; else if cnt_en, val <= val ± 1 mod 2^WIDTH, per cnt_mode. The controller never asserts cnt_clr and cnt_en together.
- FSM states: IDLE, CLEAR, UP, DOWN, DONE.
- IDLE:
  - start=1 and abort=0 latches cfg_target, cfg_laps (0 becomes 1) and cfg_clear.
  - Clears lap_cnt.
  - Next state is CLEAR if cfg_clear, else UP.
- CLEAR: cnt_clr=1 for exactly one cycle, then UP.
- UP:
  - cnt_mode=0; cnt_en = (cnt_val != target).
  - When cnt_val == target, next state is DOWN and there is no step that cycle.
  - An uncleared start with cnt_val > target wraps through 31→0 up to target.
- DOWN:
  - cnt_mode=1; cnt_en = (cnt_val != 0).
  - When cnt_val == 0: lap_cnt increments; next state is DONE if the new lap_cnt == laps, else UP.
- DONE: done=1 for one cycle, then IDLE. lap_cnt holds until the next accepted start.
- cnt_en, cnt_mode and cnt_clr are combinational from state and cnt_val. Outside UP/DOWN they are cnt_en=0 and cnt_mode=0; cnt_clr=1 only in CLEAR.
- start while busy: ignored; configuration is not re-latched.
- abort in any state other than IDLE: next state is IDLE. No done pulse; lap_cnt keeps its value; the counter holds its value.
- abort in IDLE takes priority over start: start is ignored.
- target == 0: each lap is one UP dwell cycle plus one DOWN dwell cycle with no steps.

## Timing
- Reset values: state IDLE, cnt_en 0, cnt_mode 0, cnt_clr 0, busy 0, done 0, lap_cnt 0, latched configuration 0.
- Reset mid-sweep: all outputs take their reset values immediately (asynchronously). No done pulse.
- busy rises the cycle after the edge that accepts start (edge E0).
- Latency with cfg_clear=1, target T, laps L: the last state edge is E0+1+L·(2T+2); done is high in the following cycle; busy falls one edge later.
- Without clear, from starting value v ≤ T: done follows edge E0 + (T−v) + 1 + T + 1 + (L−1)(2T+2).
- Each DOWN→UP turnaround costs no extra cycle beyond the zero-dwell cycle.
- cnt_val is sampled every cycle, so the counter must be registered with no added latency.

## Test plan
- Clear, target 3, laps 1: cnt_val sequence 0,1,2,3,3,2,1,0,0; done is high exactly in the cycle after edge E9; lap_cnt=1; busy falls after done.
- Clear, target 2, laps 3: three bounces 0→2→0; lap_cnt steps 1,2,3; single done after edge E19; cnt_mode toggles exactly at the 2 and 0 dwells.
- laps=0, target 0, clear: treated as one lap; done after edge E3; cnt_en never asserted.
- No clear, cnt_val=30, target 1, laps 1: UP wraps 30,31,0,1, then DOWN 1,0; done pulses; no cnt_clr ever asserted.
- Abort in UP at cnt_val=5 (target 10): next cycle IDLE, cnt_en=0, no done, counter holds 5. A start pulsed mid-run before the abort is ignored (lap_cnt and target unchanged).
- rst asserted mid-DOWN: outputs drop to reset values without waiting for an edge. After release, a start with clear, target 1, laps 1 completes normally with done after edge E5.
